// File: rtl/line_sequencer.sv
// Point FIFO plus stroke sequencer feeding one line command at a time to the rasteriser.
// Optional LINE_SEQ_DUP_FILTER_EN: pen-down points equal to the anchor are consumed silently.
module line_sequencer #(
    parameter int WIDTH      = 10,
    parameter int FIFO_DEPTH = 8,
    parameter int MAX_X      = 639,
    parameter int MAX_Y      = 479
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clk_en,
    input  logic [WIDTH-1:0]              pt_x,
    input  logic [WIDTH-1:0]              pt_y,
    input  logic                          pt_pen,
    input  logic                          pt_valid,
    output logic                          pt_ready,
    output logic                          overflow,
    output logic [WIDTH-1:0]              line_x0,
    output logic [WIDTH-1:0]              line_y0,
    output logic [WIDTH-1:0]              line_x1,
    output logic [WIDTH-1:0]              line_y1,
    output logic                          line_start,
    input  logic                          line_done,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [WIDTH-1:0] XLIM = WIDTH'(MAX_X);
    localparam logic [WIDTH-1:0] YLIM = WIDTH'(MAX_Y);

    typedef enum logic [2:0] {IDLE, POP, START, ARM, WAIT} state_t;

    state_t            state;
    logic [2*WIDTH:0]  mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       level;
    logic [WIDTH-1:0]  cx, cy, hx, hy, ax, ay;
    logic              hpen, anchor_valid, push, pop, dup;

    always_comb begin
        cx         = (pt_x > XLIM) ? XLIM : pt_x;
        cy         = (pt_y > YLIM) ? YLIM : pt_y;
        {hpen, hx, hy} = mem[rd_ptr];
        pt_ready   = (level != (AW+1)'(FIFO_DEPTH));
        push       = pt_valid & pt_ready;
        pop        = (state == POP);
        busy       = (level != '0) || (state != IDLE);
        fifo_level = level;
    end

`ifdef LINE_SEQ_DUP_FILTER_EN
    assign dup = anchor_valid && (hx == ax) && (hy == ay);
`else
    assign dup = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (clk_en && push)
            mem[wr_ptr] <= {pt_pen, cx, cy};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            overflow     <= 1'b0;
            anchor_valid <= 1'b0;
            ax           <= '0;
            ay           <= '0;
            line_x0      <= '0;
            line_y0      <= '0;
            line_x1      <= '0;
            line_y1      <= '0;
            line_start   <= 1'b0;
        end else if (clk_en) begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: ;
            endcase
            if (pt_valid && !pt_ready)
                overflow <= 1'b1;

            case (state)
                IDLE: if (level != '0) state <= POP;
                POP: begin
                    if (!hpen) begin
                        anchor_valid <= 1'b0;
                        state        <= IDLE;
                    end else if (!anchor_valid) begin
                        ax           <= hx;
                        ay           <= hy;
                        anchor_valid <= 1'b1;
                        state        <= IDLE;
                    end else if (dup) begin
                        state <= IDLE;
                    end else begin
                        line_x0    <= ax;
                        line_y0    <= ay;
                        line_x1    <= hx;
                        line_y1    <= hy;
                        line_start <= 1'b1;
                        state      <= START;
                    end
                end
                START: begin
                    line_start <= 1'b0;
                    state      <= ARM;
                end
                // done may still be high from the previous line for one cycle
                ARM: state <= WAIT;
                WAIT: begin
                    if (line_done) begin
                        ax    <= line_x1;
                        ay    <= line_y1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_line_sequencer.sv
// Self-checking bench for line_sequencer: directed phases plus random strokes against a polyline model.
module tb_line_sequencer;

    localparam int W = 10;
    localparam int D = 8;

    logic         clk = 0, reset = 1, clk_en = 0;
    logic [W-1:0] pt_x = '0, pt_y = '0;
    logic         pt_pen = 0, pt_valid = 0, line_done = 1;
    logic         pt_ready, overflow, line_start, busy;
    logic [W-1:0] line_x0, line_y0, line_x1, line_y1;
    logic [3:0]   fifo_level;

    line_sequencer #(.WIDTH(W), .FIFO_DEPTH(D), .MAX_X(639), .MAX_Y(479)) dut (
        .clk(clk), .reset(reset), .clk_en(clk_en),
        .pt_x(pt_x), .pt_y(pt_y), .pt_pen(pt_pen), .pt_valid(pt_valid),
        .pt_ready(pt_ready), .overflow(overflow),
        .line_x0(line_x0), .line_y0(line_y0), .line_x1(line_x1), .line_y1(line_y1),
        .line_start(line_start), .line_done(line_done),
        .busy(busy), .fifo_level(fifo_level)
    );

    initial forever #5 clk = ~clk;

    typedef struct {int x0; int y0; int x1; int y1;} line_t;
    line_t expq[$], gotq[$];
    int    st_real[$], st_en[$];
    int    total = 0, passed = 0;
    int    cyc = 0, ecyc = 0, dcnt = 0;
    int    done_mode = 0;       // 0 auto rasteriser, 1 done held low, 2 done held high
    bit    en_tog = 0;
    int    anc_x, anc_y;
    bit    anc_v = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // Stroke model: pen-down runs form a polyline, pen-up breaks it.
    function automatic void model_point(input int x, input int y, input bit pen);
        int cxv, cyv;
        cxv = (x > 639) ? 639 : x;
        cyv = (y > 479) ? 479 : y;
        if (!pen) anc_v = 0;
        else if (!anc_v) begin anc_x = cxv; anc_y = cyv; anc_v = 1; end
`ifdef LINE_SEQ_DUP_FILTER_EN
        else if (cxv == anc_x && cyv == anc_y) ;
`endif
        else begin
            expq.push_back('{anc_x, anc_y, cxv, cyv});
            anc_x = cxv; anc_y = cyv;
        end
    endfunction

    function automatic void model_reset();
        anc_v = 0;
        expq.delete();
        gotq.delete();
    endfunction

    // line monitor
    initial forever begin
        @(negedge clk);
        if (reset && clk_en && line_start) begin
            gotq.push_back('{int'(line_x0), int'(line_y0), int'(line_x1), int'(line_y1)});
            st_real.push_back(cyc);
            st_en.push_back(ecyc);
        end
        cyc++;
        if (clk_en) ecyc++;
    end

    // rasteriser stand-in
    initial forever begin
        @(negedge clk);
        case (done_mode)
            1: line_done = 0;
            2: line_done = 1;
            default: begin
                if (clk_en && line_start) begin
                    line_done = 0;
                    dcnt = $urandom_range(1, 6);
                end else if (dcnt > 0) dcnt--;
                else line_done = 1;
            end
        endcase
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (en_tog) clk_en = ~clk_en;
    end

    task automatic push(input int x, input int y, input bit pen);
        bit en;
        @(posedge clk); #2;
        pt_x = x[W-1:0]; pt_y = y[W-1:0]; pt_pen = pen; pt_valid = 1;
        do begin
            @(negedge clk); en = clk_en;
            @(posedge clk);
        end while (!en);
        #2 pt_valid = 0;
        model_point(x, y, pen);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        do begin @(posedge clk); #2; n++; end while (busy && n < budget);
        check("idle_timeout", (n >= budget), 0);
        check("idle_level", fifo_level, 0);
    endtask

    task automatic wait_start(input int budget);
        int n = 0;
        do begin @(posedge clk); #2; n++; end while (!line_start && n < budget);
        check("start_timeout", (n >= budget), 0);
    endtask

    task automatic compare_lines(input string tag);
        check({tag, "_count"}, gotq.size(), expq.size());
        for (int i = 0; i < expq.size() && i < gotq.size(); i++) begin
            check({tag, "_x0"}, gotq[i].x0, expq[i].x0);
            check({tag, "_y0"}, gotq[i].y0, expq[i].y0);
            check({tag, "_x1"}, gotq[i].x1, expq[i].x1);
            check({tag, "_y1"}, gotq[i].y1, expq[i].y1);
        end
        gotq.delete();
        expq.delete();
    endtask

    task automatic check_gaps(input string tag, input bit real_time);
        for (int i = 1; i < st_en.size(); i++) begin
            if (real_time) check({tag, "_gap"}, (st_real[i] - st_real[i-1]) >= 10, 1);
            else           check({tag, "_gap"}, (st_en[i] - st_en[i-1]) >= 5, 1);
        end
        st_real.delete();
        st_en.delete();
    endtask

    initial begin
        int n;
        #1 reset = 0;
        clk_en = 1;
        repeat (3) @(posedge clk);
        #2;
        check("rst_ready", pt_ready, 1);
        check("rst_overflow", overflow, 0);
        check("rst_start", line_start, 0);
        check("rst_busy", busy, 0);
        check("rst_level", fifo_level, 0);
        check("rst_x0", line_x0, 0);
        check("rst_y1", line_y1, 0);
        reset = 1;
        model_reset();

        // basic pair
        push(10, 20, 1);
        push(100, 50, 1);
        wait_idle(100);
        compare_lines("pair");
        check("pair_hold_x0", line_x0, 10);
        check("pair_hold_x1", line_x1, 100);
        check("pair_busy", busy, 0);

        // pen-up breaks the stroke
        push(1, 1, 0);
        push(0, 0, 1); push(5, 5, 0); push(9, 9, 1); push(20, 9, 1);
        wait_idle(100);
        compare_lines("penup");

        // clamping and boundaries
        push(1, 1, 0);
        push(700, 500, 1); push(0, 0, 1); push(639, 479, 1); push(640, 480, 1);
        wait_idle(150);
        compare_lines("clamp");

        // duplicate point
        push(2, 2, 0);
        push(30, 30, 1); push(30, 30, 1);
        wait_idle(100);
        compare_lines("dup");

        // random strokes
        for (int b = 0; b < 6; b++) begin
            n = $urandom_range(1, 4);
            for (int k = 0; k < n; k++)
                push($urandom_range(0, 1023), $urandom_range(0, 1023), ($urandom_range(0, 3) != 0));
            wait_idle(300);
        end
        compare_lines("random");

        // done held high: ARM must keep each line at least 5 enabled cycles
        done_mode = 2;
        st_real.delete(); st_en.delete();
        push(3, 3, 0);
        push(40, 41, 1); push(42, 43, 1); push(44, 45, 1); push(46, 47, 1);
        wait_idle(200);
        compare_lines("donehi");
        check_gaps("donehi", 0);

        // same with clk_en toggling
        en_tog = 1;
        push(3, 3, 0);
        push(60, 61, 1); push(62, 63, 1); push(64, 65, 1); push(66, 67, 1);
        wait_idle(400);
        en_tog = 0;
        @(posedge clk); #2 clk_en = 1;
        compare_lines("toggle");
        check_gaps("toggle", 1);

        // clk_en low holds everything, including the start pulse
        done_mode = 1;
        push(4, 4, 0);
        push(50, 60, 1);
        wait_idle(100);
        push(70, 80, 1);
        wait_start(20);
        clk_en = 0;
        pt_x = 10'd99; pt_y = 10'd99; pt_pen = 1; pt_valid = 1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #2;
            check("hold_start", line_start, 1);
            check("hold_level", fifo_level, 0);
            check("hold_x0", line_x0, 50);
            check("hold_x1", line_x1, 70);
        end
        pt_valid = 0;
        clk_en = 1;
        repeat (4) @(posedge clk);
        #2;
        check("wait_start_low", line_start, 0);
        check("wait_busy", busy, 1);
        compare_lines("hold");

        // reset during WAIT with points buffered
        push(90, 90, 1);
        push(91, 91, 1);
        check("prerst_level", fifo_level, 2);
        @(posedge clk); #3 reset = 0;
        #1;
        check("midrst_start", line_start, 0);
        check("midrst_level", fifo_level, 0);
        check("midrst_ready", pt_ready, 1);
        check("midrst_busy", busy, 0);
        @(posedge clk); #2 reset = 1;
        model_reset();
        done_mode = 0;
        push(11, 11, 1);
        wait_idle(100);
        compare_lines("after_reset");

        // overflow: rasteriser stalled, offer 10 points back to back
        done_mode = 1;
        push(200, 100, 1);
        wait_start(20);
        for (int i = 0; i <= 10; i++) begin
            @(posedge clk); #2;
            if (i > 0) begin
                check("ovf_level", fifo_level, (i < D) ? i : D);
                check("ovf_ready", pt_ready, (i < D));
                check("ovf_flag", overflow, (i >= D + 1));
            end
            if (i < 10) begin
                pt_x = 10'(300 + i * 10); pt_y = 10'(100 + i); pt_pen = 1; pt_valid = 1;
                if (i < D) model_point(300 + i * 10, 100 + i, 1);
            end else pt_valid = 0;
        end
        done_mode = 0;
        wait_idle(600);
        compare_lines("drain");
        check("ovf_sticky", overflow, 1);
        @(posedge clk); #3 reset = 0;
        #1 check("ovf_cleared", overflow, 0);
        @(posedge clk); #2 reset = 1;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
